// File: rtl/vsa_pkg.sv
// Shared definitions for the parametrised VSA multi-cycle core.
// Holds the FSM state encoding, the opcode and ALU function codes, and the
// helpers that derive instruction and immediate widths from the register-address width.
package vsa_pkg;

   // FSM states
   localparam logic [2:0] StIf   = 3'd0;
   localparam logic [2:0] StId   = 3'd1;
   localparam logic [2:0] StEx   = 3'd2;
   localparam logic [2:0] StMem  = 3'd3;
   localparam logic [2:0] StWb   = 3'd4;
   localparam logic [2:0] StHalt = 3'd5;

   // Opcodes
   localparam logic [2:0] OpLw   = 3'd0;
   localparam logic [2:0] OpSw   = 3'd1;
   localparam logic [2:0] OpBeqz = 3'd2;
   localparam logic [2:0] OpAlu  = 3'd3;
   localparam logic [2:0] OpAddi = 3'd4;
   localparam logic [2:0] OpSubi = 3'd5;
   localparam logic [2:0] OpBnez = 3'd6;
   localparam logic [2:0] OpHalt = 3'd7;

   // ALU function codes (R-format)
   localparam logic [2:0] FnAdd = 3'd0;
   localparam logic [2:0] FnSub = 3'd1;
   localparam logic [2:0] FnAnd = 3'd2;
   localparam logic [2:0] FnOr  = 3'd3;
   localparam logic [2:0] FnXor = 3'd4;
   localparam logic [2:0] FnNot = 3'd5;
   localparam logic [2:0] FnSrl = 3'd6;
   localparam logic [2:0] FnSra = 3'd7;

   // Instruction width: opcode(3) + three register fields + func(3)
   function automatic int unsigned calcIw(input int unsigned raw);
      return 6 + 3 * raw;
   endfunction

   // Immediate width: the rd and func fields of the R-format merged
   function automatic int unsigned calcImw(input int unsigned raw);
      return raw + 3;
   endfunction

endpackage

// File: rtl/vsa_param_core_if.sv
// Memory-side bus of the VSA core.
// master (core): drives pc, alu_output, dataout, wr, rd;
//                samples instruction, imem_ready, datain, dmem_ready.
// slave (memory models): the reverse directions.
interface vsa_param_core_if #(
   parameter int unsigned DW  = 5,
   parameter int unsigned RAW = 2,
   parameter int unsigned PCW = 5
) ();
   import vsa_pkg::*;

   localparam int unsigned IW = calcIw(RAW);

   logic [PCW-1:0] pc;
   logic [IW-1:0]  instruction;
   logic           imem_ready;
   logic [DW-1:0]  alu_output;
   logic [DW-1:0]  datain;
   logic [DW-1:0]  dataout;
   logic           wr;
   logic           rd;
   logic           dmem_ready;

   modport master (
      output pc, alu_output, dataout, wr, rd,
      input  instruction, imem_ready, datain, dmem_ready
   );

   modport slave (
      input  pc, alu_output, dataout, wr, rd,
      output instruction, imem_ready, datain, dmem_ready
   );

endinterface

// File: rtl/vsa_alu.sv
// Combinational execute-stage datapath of the VSA core.
// Ports: a, b (register operands), imm (sign-extended immediate), opcode, func -> result.
// Branch targets are formed in the core, so branch and HALT opcodes yield 0 here.
module vsa_alu
   import vsa_pkg::*;
#(
   parameter int unsigned DW = 5
) (
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic [DW-1:0] imm,
   input  logic [2:0]    opcode,
   input  logic [2:0]    func,
   output logic [DW-1:0] result
);

   always_comb begin
      result = '0;
      case (opcode)
         OpLw, OpSw, OpAddi: result = a + imm;
         OpSubi:             result = a - imm;
         OpAlu: begin
            case (func)
               FnAdd:   result = a + b;
               FnSub:   result = a - b;
               FnAnd:   result = a & b;
               FnOr:    result = a | b;
               FnXor:   result = a ^ b;
               FnNot:   result = ~a;
               FnSrl:   result = a >> b;
               FnSra:   result = DW'($signed(a) >>> b);
               default: result = '0;
            endcase
         end
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/vsa_param_core.sv
// Parametrised VSA multi-cycle core: IF -> ID -> EX -> MEM -> WB, plus an absorbing HALT.
// Ports: clock, reset (synchronous, active-high), bus (master side of the memory
// interface), halted (high while in HALT).
// IF stalls on imem_ready, MEM stalls on dmem_ready for LW/SW only.
module vsa_param_core
   import vsa_pkg::*;
#(
   parameter int unsigned DW      = 5,
   parameter int unsigned RAW     = 2,
   parameter int unsigned PCW     = 5,
   parameter int unsigned PC_STEP = 2
) (
   input  logic             clock,
   input  logic             reset,
   vsa_param_core_if.master bus,
   output logic             halted
);

   localparam int unsigned IW   = calcIw(RAW);
   localparam int unsigned IMW  = calcImw(RAW);
   localparam int unsigned NREG = 2 ** RAW;
   localparam logic [PCW-1:0] PcInc = PCW'(PC_STEP);

   logic [2:0]     state;
   logic [PCW-1:0] pcReg;
   logic [PCW-1:0] npc;
   logic [IW-1:0]  ir;
   logic [DW-1:0]  regA;
   logic [DW-1:0]  regB;
   logic [DW-1:0]  aluOutput;
   logic [DW-1:0]  lmd;
   logic           cond;
   logic [DW-1:0]  regFile [NREG];

   // Instruction fields; I-format reuses the rs2 slot as its destination
   logic [2:0]     opcode;
   logic [2:0]     func;
   logic [RAW-1:0] rs1;
   logic [RAW-1:0] rs2;
   logic [RAW-1:0] rdField;
   logic [IMW-1:0] immField;

   assign opcode   = ir[IW-1 -: 3];
   assign rs1      = ir[IW-4 -: RAW];
   assign rs2      = ir[IW-4-RAW -: RAW];
   assign rdField  = ir[3 +: RAW];
   assign func     = ir[2:0];
   assign immField = ir[IMW-1:0];

   logic           isBranch;
   logic           isMem;
   logic [DW-1:0]  immExt;
   logic [PCW-1:0] branchOff;
   logic [PCW-1:0] branchTarget;
   logic [PCW-1:0] pcFromAlu;
   logic [DW-1:0]  aluResult;
   logic [DW-1:0]  readA;
   logic [DW-1:0]  readB;

   assign isBranch = (opcode == OpBeqz) || (opcode == OpBnez);
   assign isMem    = (opcode == OpLw) || (opcode == OpSw);

   // Size casts sign-extend (or truncate) the signed immediate to the target width
   assign immExt       = DW'($signed(immField));
   assign branchOff    = PCW'($signed(immField)) << 1;
   assign branchTarget = npc + branchOff;
   assign pcFromAlu    = PCW'(aluOutput);

   assign readA = (rs1 == '0) ? '0 : regFile[rs1];
   assign readB = (rs2 == '0) ? '0 : regFile[rs2];

   vsa_alu #(
      .DW(DW)
   ) alu (
      .a      (regA),
      .b      (regB),
      .imm    (immExt),
      .opcode (opcode),
      .func   (func),
      .result (aluResult)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= StIf;
         pcReg     <= '0;
         npc       <= '0;
         ir        <= '0;
         regA      <= '0;
         regB      <= '0;
         aluOutput <= '0;
         lmd       <= '0;
         cond      <= 1'b0;
         for (int i = 0; i < NREG; i++) begin
            regFile[i] <= '0;
         end
      end else begin
         case (state)
            StIf: begin
               if (bus.imem_ready) begin
                  ir    <= bus.instruction;
                  npc   <= pcReg + PcInc;
                  state <= StId;
               end
            end
            StId: begin
               regA  <= readA;
               regB  <= readB;
               state <= StEx;
            end
            StEx: begin
               // Branch target is held in ALUOutput, zero-extended from PCW bits
               aluOutput <= isBranch ? DW'(branchTarget) : aluResult;
               if (opcode == OpBeqz) cond <= (regA == '0);
               if (opcode == OpBnez) cond <= (regA != '0);
               state <= (opcode == OpHalt) ? StHalt : StMem;
            end
            StMem: begin
               if (!isMem || bus.dmem_ready) begin
                  if (opcode == OpLw) lmd <= bus.datain;
                  pcReg <= (isBranch && cond) ? pcFromAlu : npc;
                  state <= StWb;
               end
            end
            StWb: begin
               case (opcode)
                  OpAlu: begin
                     if (rdField != '0) regFile[rdField] <= aluOutput;
                  end
                  OpAddi, OpSubi: begin
                     if (rs2 != '0) regFile[rs2] <= aluOutput;
                  end
                  OpLw: begin
                     if (rs2 != '0) regFile[rs2] <= lmd;
                  end
                  default: ;
               endcase
               state <= StIf;
            end
            StHalt: state <= StHalt;
            default: state <= StIf;
         endcase
      end
   end

   assign bus.pc         = pcReg;
   assign bus.alu_output = aluOutput;
   assign bus.dataout    = regB;
   assign bus.wr         = (state == StMem) && (opcode == OpSw);
   assign bus.rd         = (state == StMem) && (opcode == OpLw);
   assign halted         = (state == StHalt);

endmodule

// File: tb/tb_vsa_param_core.sv
// Self-checking bench for vsa_param_core: directed scenarios plus random programs
// checked against an instruction-level reference model through a data-access scoreboard.
module tb_vsa_param_core;
   import vsa_pkg::*;

   localparam int unsigned DW      = 8;
   localparam int unsigned RAW     = 2;
   localparam int unsigned PCW     = 5;
   localparam int unsigned PC_STEP = 2;
   localparam int unsigned IW      = calcIw(RAW);
   localparam int unsigned IMW     = calcImw(RAW);

   typedef struct {
      bit            isStore;
      logic [DW-1:0] addr;
      logic [DW-1:0] data;
   } access_t;

   access_t expQ[$];
   int compared   = 0;
   int mismatched = 0;

   logic clock     = 1'b0;
   logic reset     = 1'b1;
   logic imemReady = 1'b1;
   logic dmemReady = 1'b1;
   logic halted;
   bit   stallMode = 1'b0;

   logic [IW-1:0] imem [32];
   logic [DW-1:0] dmem [256];
   logic [DW-1:0] mReg [4];
   logic [DW-1:0] mMem [256];

   vsa_param_core_if #(.DW(DW), .RAW(RAW), .PCW(PCW)) bus ();

   vsa_param_core #(
      .DW(DW), .RAW(RAW), .PCW(PCW), .PC_STEP(PC_STEP)
   ) dut (
      .clock  (clock),
      .reset  (reset),
      .bus    (bus),
      .halted (halted)
   );

   assign bus.instruction = imem[bus.pc];
   assign bus.datain      = dmem[bus.alu_output];
   assign bus.imem_ready  = imemReady;
   assign bus.dmem_ready  = dmemReady;

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic startRun();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic waitHalted(input int maxCycles, output int cycles);
      cycles = 0;
      while (halted !== 1'b1 && cycles < maxCycles) begin
         tick();
         cycles++;
      end
      if (halted !== 1'b1) begin
         compared++;
         mismatched++;
         $display("FAIL halt_timeout: not halted after %0d cycles", cycles);
      end
   endtask

   task automatic pushExp(input bit isStore, input int addr, input int data);
      access_t e;
      e.isStore = isStore;
      e.addr    = DW'(addr);
      e.data    = DW'(data);
      expQ.push_back(e);
   endtask

   function automatic logic [IW-1:0] encI(input logic [2:0] op, input logic [RAW-1:0] s1,
                                          input logic [RAW-1:0] t, input logic [IMW-1:0] imm);
      return {op, s1, t, imm};
   endfunction

   task automatic clearImem();
      for (int i = 0; i < 32; i++) imem[i] = encI(OpHalt, 2'd0, 2'd0, 5'd0);
   endtask

   function automatic int wrapD(input int x);
      return ((x % (1 << DW)) + (1 << DW)) % (1 << DW);
   endfunction

   function automatic int wrapP(input int x);
      return ((x % (1 << PCW)) + (1 << PCW)) % (1 << PCW);
   endfunction

   function automatic logic [IW-1:0] randInstr();
      int r;
      logic [IW-1:0] w;
      r = $urandom_range(0, 15);
      w = IW'($urandom);
      case (r)
         0, 1:      w[IW-1 -: 3] = OpLw;
         2, 3, 4:   w[IW-1 -: 3] = OpSw;
         5:         w[IW-1 -: 3] = OpBeqz;
         6, 7, 8:   w[IW-1 -: 3] = OpAlu;
         9, 10, 15: w[IW-1 -: 3] = OpAddi;
         11, 12:    w[IW-1 -: 3] = OpSubi;
         13:        w[IW-1 -: 3] = OpBnez;
         default:   w[IW-1 -: 3] = OpHalt;
      endcase
      return w;
   endfunction

   // Instruction-level model: executes the program, queues the expected data accesses
   task automatic runModel(input int maxSteps, output bit done, output int haltPc);
      int pcv;
      pcv    = 0;
      done   = 1'b0;
      haltPc = 0;
      for (int i = 0; i < 4; i++) mReg[i] = '0;
      for (int step = 0; step < maxSteps && !done; step++) begin
         logic [IW-1:0] ins;
         int op, s1, s2, d, fn, immS, a, b, npc, nextPc, res, sa, addr;
         ins  = imem[pcv];
         op   = int'(ins[IW-1 -: 3]);
         s1   = int'(ins[IW-4 -: RAW]);
         s2   = int'(ins[IW-4-RAW -: RAW]);
         d    = int'(ins[3 +: RAW]);
         fn   = int'(ins[2:0]);
         immS = int'(ins[IMW-1:0]);
         if (immS >= (1 << (IMW - 1))) immS = immS - (1 << IMW);
         a      = (s1 == 0) ? 0 : int'(mReg[s1]);
         b      = (s2 == 0) ? 0 : int'(mReg[s2]);
         npc    = wrapP(pcv + PC_STEP);
         nextPc = npc;
         addr   = wrapD(a + immS);
         case (op)
            0: begin
               pushExp(1'b0, addr, 0);
               if (s2 != 0) mReg[s2] = mMem[addr];
            end
            1: begin
               pushExp(1'b1, addr, b);
               mMem[addr] = DW'(b);
            end
            2: if (a == 0) nextPc = wrapP(npc + 2 * immS);
            3: begin
               sa = (a >= (1 << (DW - 1))) ? a - (1 << DW) : a;
               case (fn)
                  0: res = wrapD(a + b);
                  1: res = wrapD(a - b);
                  2: res = a & b;
                  3: res = a | b;
                  4: res = a ^ b;
                  5: res = (1 << DW) - 1 - a;
                  6: res = a >> b;
                  default: res = wrapD(sa >>> b);
               endcase
               if (d != 0) mReg[d] = DW'(res);
            end
            4: if (s2 != 0) mReg[s2] = DW'(wrapD(a + immS));
            5: if (s2 != 0) mReg[s2] = DW'(wrapD(a - immS));
            6: if (a != 0) nextPc = wrapP(npc + 2 * immS);
            default: begin
               done   = 1'b1;
               haltPc = pcv;
            end
         endcase
         if (!done) pcv = nextPc;
      end
   endtask

   // Scoreboard monitor: every completed data access must match the queue front
   always @(negedge clock) begin
      access_t e;
      if (reset === 1'b0 && (bus.wr === 1'b1 || bus.rd === 1'b1) && bus.dmem_ready === 1'b1) begin
         if (expQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_access: wr=%0b rd=%0b addr=%0h", bus.wr, bus.rd,
                     bus.alu_output);
         end else begin
            e = expQ.pop_front();
            check("acc_is_store", 32'(bus.wr), 32'(e.isStore));
            check("acc_wr_rd_excl", 32'(bus.wr & bus.rd), 32'd0);
            check("acc_addr", 32'(bus.alu_output), 32'(e.addr));
            if (e.isStore) begin
               check("st_data", 32'(bus.dataout), 32'(e.data));
               dmem[bus.alu_output] <= bus.dataout;
            end
         end
      end
   end

   // Random ready stalls for the randomized programs
   initial forever begin
      @(posedge clock);
      #1;
      if (stallMode) begin
         imemReady = ($urandom_range(0, 3) != 0);
         dmemReady = ($urandom_range(0, 2) != 0);
      end
   end

   initial begin
      int cyc, cnt, haltPc;
      bit seen, frozen, ok;
      logic [DW-1:0] addrSeen, savedAlu;

      for (int i = 0; i < 256; i++) dmem[i] = '0;
      clearImem();

      // Reset values
      reset = 1'b1;
      tick();
      tick();
      check("rst_pc", 32'(bus.pc), 32'd0);
      check("rst_alu_output", 32'(bus.alu_output), 32'd0);
      check("rst_dataout", 32'(bus.dataout), 32'd0);
      check("rst_wr", 32'(bus.wr), 32'd0);
      check("rst_rd", 32'(bus.rd), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);

      // ADDI R1,R0,5 then store R1 to observe it
      clearImem();
      imem[0] = encI(OpAddi, 2'd0, 2'd1, 5'd5);
      imem[2] = encI(OpSw, 2'd0, 2'd1, 5'd0);
      expQ.delete();
      pushExp(1'b1, 0, 5);
      startRun();
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (bus.wr !== 1'b0 || bus.rd !== 1'b0) seen = 1'b1;
      end
      check("t1_pc_after_5", 32'(bus.pc), 32'd2);
      check("t1_no_wr_rd", 32'(seen), 32'd0);
      waitHalted(100, cyc);
      check("t1_halt_cycles", 32'(cyc), 32'd8);
      check("t1_halt_pc", 32'(bus.pc), 32'd4);
      check("t1_drain", 32'(expQ.size()), 32'd0);

      // Sign extension: ADDI R2,R0,-1; SUBI R3,R2,1
      clearImem();
      imem[0] = encI(OpAddi, 2'd0, 2'd2, 5'h1F);
      imem[2] = encI(OpSubi, 2'd2, 2'd3, 5'd1);
      imem[4] = encI(OpSw, 2'd0, 2'd2, 5'd0);
      imem[6] = encI(OpSw, 2'd0, 2'd3, 5'd1);
      expQ.delete();
      pushExp(1'b1, 0, 8'hFF);
      pushExp(1'b1, 1, 8'hFE);
      startRun();
      waitHalted(200, cyc);
      check("t2_halt_pc", 32'(bus.pc), 32'd8);
      check("t2_drain", 32'(expQ.size()), 32'd0);

      // SW with A=3, Imm=4 and three data-stall cycles
      clearImem();
      imem[0] = encI(OpAddi, 2'd0, 2'd1, 5'd3);
      imem[2] = encI(OpAddi, 2'd0, 2'd2, 5'd9);
      imem[4] = encI(OpSw, 2'd1, 2'd2, 5'd4);
      expQ.delete();
      pushExp(1'b1, 7, 9);
      dmemReady = 1'b0;
      startRun();
      cnt      = 0;
      cyc      = 0;
      addrSeen = '0;
      while (halted !== 1'b1 && cyc < 60) begin
         tick();
         cyc++;
         if (bus.wr === 1'b1) begin
            cnt++;
            if (cnt == 1) addrSeen = bus.alu_output;
         end
         dmemReady = (cnt >= 4);
      end
      dmemReady = 1'b1;
      check("t3_wr_cycles", 32'(cnt), 32'd4);
      check("t3_addr", 32'(addrSeen), 32'd7);
      check("t3_cycles_to_halt", 32'(cyc), 32'd21);
      check("t3_drain", 32'(expQ.size()), 32'd0);

      // BEQZ taken at pc=4 to 12, BNEZ not taken at 12 to 14
      clearImem();
      imem[0]  = encI(OpAddi, 2'd0, 2'd2, 5'd1);
      imem[2]  = encI(OpAddi, 2'd0, 2'd1, 5'd0);
      imem[4]  = encI(OpBeqz, 2'd1, 2'd0, 5'd3);
      imem[12] = encI(OpBnez, 2'd1, 2'd0, 5'd3);
      imem[14] = encI(OpSw, 2'd0, 2'd2, 5'd0);
      expQ.delete();
      pushExp(1'b1, 0, 1);
      startRun();
      for (int i = 0; i < 15; i++) tick();
      check("t4_beqz_pc", 32'(bus.pc), 32'd12);
      waitHalted(200, cyc);
      check("t4_halt_pc", 32'(bus.pc), 32'd16);
      check("t4_drain", 32'(expQ.size()), 32'd0);

      // Backward branch wrapping to 30, ADDI at 30 wraps pc to 0, then HALT freeze
      clearImem();
      imem[0]  = encI(OpBeqz, 2'd1, 2'd0, 5'h1E);
      imem[30] = encI(OpAddi, 2'd0, 2'd1, 5'd7);
      imem[2]  = encI(OpSw, 2'd0, 2'd1, 5'd0);
      expQ.delete();
      pushExp(1'b1, 0, 7);
      startRun();
      for (int i = 0; i < 5; i++) tick();
      check("t5_back_branch_pc", 32'(bus.pc), 32'd30);
      for (int i = 0; i < 5; i++) tick();
      check("t5_wrap_pc", 32'(bus.pc), 32'd0);
      waitHalted(200, cyc);
      check("t5_halt_pc", 32'(bus.pc), 32'd4);
      check("t5_drain", 32'(expQ.size()), 32'd0);
      savedAlu = bus.alu_output;
      frozen   = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.pc !== 5'd4 || halted !== 1'b1 || bus.alu_output !== savedAlu ||
             bus.wr !== 1'b0 || bus.rd !== 1'b0) frozen = 1'b0;
      end
      check("t5_halt_frozen", 32'(frozen), 32'd1);

      // Reset while a LW is stalled in MEM; registers must come back as zero
      clearImem();
      imem[0] = encI(OpAddi, 2'd0, 2'd1, 5'd1);
      imem[2] = encI(OpAddi, 2'd0, 2'd2, 5'd2);
      imem[4] = encI(OpAddi, 2'd0, 2'd3, 5'd3);
      imem[6] = encI(OpLw, 2'd0, 2'd1, 5'd0);
      expQ.delete();
      dmemReady = 1'b0;
      startRun();
      cyc = 0;
      while (bus.rd !== 1'b1 && cyc < 60) begin
         tick();
         cyc++;
      end
      tick();
      tick();
      check("t6_rd_stalled", 32'(bus.rd), 32'd1);
      reset = 1'b1;
      clearImem();
      imem[0] = encI(OpSw, 2'd0, 2'd1, 5'd0);
      imem[2] = encI(OpSw, 2'd0, 2'd2, 5'd1);
      imem[4] = encI(OpSw, 2'd0, 2'd3, 5'd2);
      pushExp(1'b1, 0, 0);
      pushExp(1'b1, 1, 0);
      pushExp(1'b1, 2, 0);
      tick();
      check("t6_rd_after_reset", 32'(bus.rd), 32'd0);
      check("t6_pc_after_reset", 32'(bus.pc), 32'd0);
      reset     = 1'b0;
      dmemReady = 1'b1;
      waitHalted(200, cyc);
      check("t6_halt_pc", 32'(bus.pc), 32'd6);
      check("t6_drain", 32'(expQ.size()), 32'd0);

      // Random programs with random stalls against the reference model
      for (int t = 0; t < 25; t++) begin
         int tries;
         reset     = 1'b1;
         stallMode = 1'b0;
         imemReady = 1'b1;
         dmemReady = 1'b1;
         ok        = 1'b0;
         tries     = 0;
         while (!ok && tries < 200) begin
            for (int i = 0; i < 32; i++) imem[i] = randInstr();
            for (int i = 0; i < 256; i++) begin
               dmem[i] = DW'($urandom);
               mMem[i] = dmem[i];
            end
            expQ.delete();
            runModel(40, ok, haltPc);
            tries++;
         end
         if (!ok) begin
            $display("note: no halting program generated for run %0d", t);
            continue;
         end
         stallMode = 1'b1;
         startRun();
         waitHalted(4000, cyc);
         stallMode = 1'b0;
         imemReady = 1'b1;
         dmemReady = 1'b1;
         check("rand_halt_pc", 32'(bus.pc), 32'(haltPc));
         check("rand_drain", 32'(expQ.size()), 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/vsa_param_core.md
Name: vsa_param_core

Overview:
- Parametrised successor of the team's Very Simple Architecture multi-cycle core: non-pipelined, one instruction per 5+ cycles, no interrupts.
- Generalises data width, register count and PC width over the fixed 5-bit, 4-register generation.
- Adds sign-extended immediates, BNEZ, a HALT state, ready-based stalls on instruction and data memory, and a synchronous reset.
- Sits as the CPU model feeding instruction/data memory models in the verification benchmarks.

Parameters:
- DW, 5, data/register width in bits (≥4).
- RAW, 2, register-address bits; register file has 2**RAW entries, R0 reads as 0.
- PCW, 5, program counter width; all PC arithmetic is modulo 2**PCW.
- PC_STEP, 2, sequential PC increment.
- Derived, not overridable:
  - IW = 6+3*RAW, instruction width.
  - IMW = RAW+3, immediate width.

Ports:
- clock  in  1  master clock, rising edge
- reset  in  1  synchronous, active-high reset
- pc  out  PCW  instruction memory address
- instruction  in  IW  instruction memory data, sampled in IF when imem_ready=1
- imem_ready  in  1  instruction valid this cycle
- alu_output  out  DW  data memory address (ALU result register)
- datain  in  DW  data memory read bus
- dataout  out  DW  data memory write bus (= B register)
- wr  out  1  data write request
- rd  out  1  data read request
- dmem_ready  in  1  data access completes this cycle
- halted  out  1  core is in HALT

Behaviour:
- Clocking and reset:
  - One clock, posedge.
  - Reset is synchronous, active-high.
  - On reset: PC, NPC, IR, A, B, ALUOutput, Cond, LMD and all registers are cleared to 0, and State goes to IF.
  - Resulting output values: pc=0, alu_output=0, dataout=0, wr=0, rd=0, halted=0.
  - Reset overrides any state, including a stalled MEM or HALT.
- Instruction formats, MSB first:
  - R-format: opcode(3) rs1(RAW) rs2(RAW) rd(RAW) func(3).
  - I-format: opcode(3) rs1(RAW) rd(RAW) imm(IMW).
- Opcodes: 0 LW, 1 SW, 2 BEQZ, 3 ALU, 4 ADDI, 5 SUBI, 6 BNEZ, 7 HALT.
- ALU func: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT(~A), 6 SRL, 7 SRA.
- Immediate: sign-extended from IMW to DW (truncated if IMW>DW).
- All arithmetic is modulo 2**DW.
- Per-state actions:
  - IF: hold until imem_ready=1. Then IR<=instruction, NPC<=PC+PC_STEP, and go to ID.
  - ID (1 cycle): A<=Reg[rs1], B<=Reg[rs2/rd-field as in I-format].
  - EX (1 cycle), by opcode:
    - LW/SW: ALUOutput<=A+Imm.
    - ALU: ALUOutput<=func(A,B).
    - ADDI: ALUOutput<=A+Imm.
    - SUBI: ALUOutput<=A−Imm.
    - BEQZ/BNEZ: ALUOutput<=NPC+(Imm<<1), truncated to PCW and zero-extended to DW; Cond<=(A==0) for BEQZ, (A!=0) for BNEZ.
    - HALT: next state is HALT.
  - MEM:
    - rd is asserted combinationally for LW, wr for SW.
    - Holds until dmem_ready=1. On that edge: LMD<=datain for LW, then PC<=(branch&&Cond)?ALUOutput[PCW-1:0]:NPC.
    - Non-memory opcodes spend exactly 1 cycle in MEM; dmem_ready is ignored.
  - WB (1 cycle), then IF:
    - ALU writes Reg[rd].
    - ADDI/SUBI write Reg[rs2-field] with ALUOutput.
    - LW writes Reg[rs2-field] with LMD.
    - Writes to R0 are discarded.
  - HALT: absorbing until reset; halted=1. PC is not updated, so pc still shows the HALT instruction's address. wr=rd=0.
- Latency: 5 cycles per instruction with zero stall. Each imem_ready or dmem_ready low cycle adds exactly 1 cycle.
- Boundary conditions:
  - PC wraps at 2**PCW.
  - Branch offset negative (Imm MSB=1) wraps backward.
  - dataout always reflects B.
  - Unused State encodings return to IF.

Decomposition:
- Package vsa_pkg holds:
  - State encoding (IF, ID, EX, MEM, WB, HALT).
  - Opcode and func constants.
  - The IW/IMW derivation functions.
- One sub-module, vsa_alu: combinational, parametrised by DW; inputs A, B, Imm, opcode, func; output result.
- Register file, FSM and PC logic stay in vsa_param_core.

Test Plan:
- ADDI R1,R0,5 (defaults), imem_ready=1 -> R1=5 and pc=2 after 5 cycles; wr=rd=0 throughout.
- DW=8: ADDI R2,R0,imm=5'b11111 -> R2=8'hFF (sign extension); SUBI R3,R2,1 -> R3=8'hFE.
- SW with A=3, Imm=4, dmem_ready low 3 cycles -> wr=1 for 4 consecutive cycles, alu_output=7, instruction takes 8 cycles.
- pc=4, R1=0, BEQZ R1 imm=3 -> pc=12; then BNEZ R1 imm=3 (pc=12) -> not taken, pc=14.
- pc=30, ADDI -> pc wraps to 0. HALT -> halted=1 after EX, pc frozen, no further state change for 10 cycles.
- Reset asserted while stalled in MEM of LW (rd=1) -> next cycle rd=0, pc=0, all registers 0, core fetches from 0.
